dti_prog_dly: RTL and testbench

- Programmable-depth token delay line on dti channels.
- Accumulates N tokens (N set at run time, 1..DEPTH) before presenting any output, then streams until empty. After that it re-primes.
- Storage is a ring buffer, not a register chain. Adds early drain (flush) and occupancy/status outputs.
- Sits between producer and consumer anywhere a fixed token lag or burst-collect is needed.

---
 rtl/dti_prog_dly_pkg.sv | 10 +
 rtl/dly_ring_buf.sv | 29 ++
 rtl/dti_prog_dly.sv | 55 +++++
 tb/tb_dti_prog_dly.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dti_prog_dly_pkg.sv
// dti_prog_dly_pkg: shared state type and delay/pointer helpers for the programmable delay line
package dti_prog_dly_pkg;
  typedef enum logic {FILL, DRAIN} state_t;
  function automatic int clamp_dly(input int cfg, input int depth);
    return (cfg == 0) ? 1 : (cfg > depth) ? depth : cfg;
  endfunction
  function automatic int ptr_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/dly_ring_buf.sv
// dly_ring_buf: register-array ring buffer with explicit-compare pointer wrap
module dly_ring_buf
  import dti_prog_dly_pkg::*;
#(
  parameter int W_DIN = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [W_DIN-1:0] wr_data,
  output logic [W_DIN-1:0] rd_data
);
  localparam int PW = $clog2(DEPTH);
  logic [W_DIN-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= PW'(ptr_inc(int'(wr_ptr), DEPTH));
      if (pop) rd_ptr <= PW'(ptr_inc(int'(rd_ptr), DEPTH));
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_data;
  assign rd_data = mem[rd_ptr];
endmodule

// File: rtl/dti_prog_dly.sv
// dti_prog_dly: collects a run-time number of tokens before streaming them out in FIFO order
module dti_prog_dly
  import dti_prog_dly_pkg::*;
#(
  parameter int W_DIN = 16,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W_DIN-1:0] din_data,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [W_DIN-1:0] dout_data,
  output logic             dout_valid,
  input  logic             dout_ready,
  input  logic [CW-1:0]    cfg_dly,
  input  logic             flush,
  output logic [CW-1:0]    count,
  output logic             primed
);
  state_t state, state_nx;
  logic [CW-1:0] dly_q, count_nx;
  logic push, pop;
  assign push = din_valid && din_ready;
  assign pop = dout_valid && dout_ready;
  assign primed = (state == DRAIN);
  // a full buffer still accepts when the head leaves in the same cycle
  always_comb begin
    dout_valid = (state == DRAIN) && (count != '0);
    din_ready = rst && ((state == FILL) ? (count < dly_q) : ((count < CW'(DEPTH)) || dout_ready));
    count_nx = (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
    state_nx = (state == FILL)
             ? (((count_nx == dly_q) || (flush && (count != '0))) ? DRAIN : FILL)
             : ((count_nx == '0) ? FILL : DRAIN);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= FILL;
      count <= '0;
      dly_q <= CW'(DEPTH);
    end else begin
      state <= state_nx;
      count <= count_nx;
      if ((state == FILL) && (count == '0)) dly_q <= CW'(clamp_dly(int'(cfg_dly), DEPTH));
    end
  dly_ring_buf #(.W_DIN(W_DIN), .DEPTH(DEPTH)) u_buf (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .wr_data(din_data),
    .rd_data(dout_data)
  );
endmodule

// File: tb/tb_dti_prog_dly.sv
// tb_dti_prog_dly: scenario tasks with a FIFO-order scoreboard for dti_prog_dly
module tb_dti_prog_dly;
  localparam int W = 16;
  localparam int D = 8;
  localparam int CW = $clog2(D + 1);
  logic clk = 0, rst = 0;
  logic [W-1:0] din_data = '0, dout_data;
  logic din_valid = 0, din_ready, dout_valid, dout_ready = 0;
  logic [CW-1:0] cfg_dly = '0, count;
  logic flush = 0, primed;
  int checks = 0, failures = 0, n_out = 0;
  bit acc_in;
  logic [W-1:0] exp_q[$];

  dti_prog_dly #(.W_DIN(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .din_data(din_data), .din_valid(din_valid), .din_ready(din_ready),
    .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .cfg_dly(cfg_dly), .flush(flush), .count(count), .primed(primed)
  );

  always #5 clk = ~clk;

  // one clock: observe handshakes at negedge, scoreboard them, return 1ns after the edge
  task automatic cyc();
    logic [W-1:0] e;
    @(negedge clk);
    acc_in = rst && din_valid && din_ready;
    if (acc_in) exp_q.push_back(din_data);
    if (rst && dout_valid && dout_ready) begin
      n_out++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected got=%h required=none", dout_data);
      end else begin
        e = exp_q.pop_front();
        if (dout_data !== e) begin
          failures++;
          $display("FAIL sb_order got=%h required=%h", dout_data, e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d);
    int i;
    din_valid = 1;
    din_data = d;
    for (i = 0; i < 50; i++) begin
      cyc();
      if (acc_in) break;
    end
    din_valid = 0;
    if (i == 50) begin
      checks++;
      failures++;
      $display("FAIL send_timeout got=stalled required=accept data=%h", d);
    end
  endtask

  task automatic wait_fill();
    int i;
    for (i = 0; i < 100 && !(primed == 0 && count == 0); i++) cyc();
    checks++;
    if (primed !== 0 || count !== 0) begin
      failures++;
      $display("FAIL wait_fill got primed=%b count=%0d required primed=0 count=0", primed, count);
    end
  endtask

  task automatic test_reset();
    din_valid = 1;
    #2;
    checks++;
    if (din_ready !== 0 || dout_valid !== 0 || count !== 0 || primed !== 0) begin
      failures++;
      $display("FAIL reset_outputs got ready=%b valid=%b count=%0d primed=%b required 0/0/0/0",
               din_ready, dout_valid, count, primed);
    end
    cyc();
    cyc();
    din_valid = 0;
    rst = 1;
  endtask

  task automatic test_basic();
    int n0;
    cfg_dly = 3;
    dout_ready = 1;
    cyc();
    n0 = n_out;
    send(16'h11);
    send(16'h22);
    checks++;
    if (dout_valid !== 0 || primed !== 0) begin
      failures++;
      $display("FAIL basic_early got valid=%b primed=%b required 0/0", dout_valid, primed);
    end
    send(16'h33);
    checks++;
    if (dout_valid !== 1 || primed !== 1 || dout_data !== 16'h11 || count !== 3) begin
      failures++;
      $display("FAIL basic_primed got valid=%b primed=%b data=%h count=%0d required 1/1/0011/3",
               dout_valid, primed, dout_data, count);
    end
    send(16'h44);
    checks++;
    if (count !== 3) begin
      failures++;
      $display("FAIL basic_pushpop got count=%0d required=3", count);
    end
    wait_fill();
    checks++;
    if (n_out - n0 !== 4) begin
      failures++;
      $display("FAIL basic_count got=%0d required=4", n_out - n0);
    end
  endtask

  task automatic test_clamp0();
    cfg_dly = 0;
    dout_ready = 1;
    cyc();
    send(16'h55);
    checks++;
    if (primed !== 1 || dout_valid !== 1 || dout_data !== 16'h55) begin
      failures++;
      $display("FAIL clamp0 got primed=%b valid=%b data=%h required 1/1/0055", primed, dout_valid, dout_data);
    end
    wait_fill();
  endtask

  task automatic test_clamp_max_backpressure();
    int n0;
    cfg_dly = 12;
    dout_ready = 0;
    cyc();
    for (int i = 0; i < 7; i++) send(W'(16'hC0 + i));
    checks++;
    if (primed !== 0 || count !== 7) begin
      failures++;
      $display("FAIL clamp12_seven got primed=%b count=%0d required 0/7", primed, count);
    end
    send(16'hC7);
    checks++;
    if (primed !== 1 || count !== 8 || din_ready !== 0) begin
      failures++;
      $display("FAIL clamp12_full got primed=%b count=%0d ready=%b required 1/8/0", primed, count, din_ready);
    end
    din_valid = 1;
    din_data = 16'h100;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if (din_ready !== 0 || dout_data !== 16'hC0 || count !== 8) begin
        failures++;
        $display("FAIL bp_hold got ready=%b data=%h count=%0d required 0/00c0/8", din_ready, dout_data, count);
      end
    end
    dout_ready = 1;
    n0 = n_out;
    for (int i = 0; i < 20; i++) begin
      send(W'(16'h100 + i));
      checks++;
      if (count !== 8) begin
        failures++;
        $display("FAIL bp_stream got count=%0d required=8 step=%0d", count, i);
      end
    end
    wait_fill();
    checks++;
    if (n_out - n0 !== 28) begin
      failures++;
      $display("FAIL bp_total got=%0d required=28", n_out - n0);
    end
  endtask

  task automatic test_flush();
    int n0;
    cfg_dly = 6;
    dout_ready = 1;
    cyc();
    n0 = n_out;
    send(16'hF1);
    send(16'hF2);
    checks++;
    if (primed !== 0 || count !== 2) begin
      failures++;
      $display("FAIL flush_pre got primed=%b count=%0d required 0/2", primed, count);
    end
    flush = 1;
    cyc();
    flush = 0;
    checks++;
    if (primed !== 1 || dout_valid !== 1 || dout_data !== 16'hF1) begin
      failures++;
      $display("FAIL flush_drain got primed=%b valid=%b data=%h required 1/1/00f1", primed, dout_valid, dout_data);
    end
    wait_fill();
    checks++;
    if (n_out - n0 !== 2) begin
      failures++;
      $display("FAIL flush_count got=%0d required=2", n_out - n0);
    end
    flush = 1;
    cyc();
    cyc();
    flush = 0;
    checks++;
    if (primed !== 0 || count !== 0 || dout_valid !== 0) begin
      failures++;
      $display("FAIL flush_empty got primed=%b count=%0d valid=%b required 0/0/0", primed, count, dout_valid);
    end
  endtask

  task automatic test_reconfig();
    int n0;
    cfg_dly = 3;
    dout_ready = 0;
    cyc();
    n0 = n_out;
    for (int i = 0; i < 3; i++) send(W'(16'hA0 + i));
    cfg_dly = 5;
    dout_ready = 1;
    wait_fill();
    checks++;
    if (n_out - n0 !== 3) begin
      failures++;
      $display("FAIL reconf_cur got=%0d required=3", n_out - n0);
    end
    cyc();
    for (int i = 0; i < 4; i++) send(W'(16'hB0 + i));
    checks++;
    if (primed !== 0 || count !== 4) begin
      failures++;
      $display("FAIL reconf_wait got primed=%b count=%0d required 0/4", primed, count);
    end
    send(16'hB4);
    checks++;
    if (primed !== 1 || dout_data !== 16'hB0) begin
      failures++;
      $display("FAIL reconf_prime got primed=%b data=%h required 1/00b0", primed, dout_data);
    end
    wait_fill();
  endtask

  task automatic test_async_reset();
    int n0;
    cfg_dly = 4;
    dout_ready = 0;
    cyc();
    for (int i = 0; i < 4; i++) send(W'(16'hD0 + i));
    checks++;
    if (primed !== 1 || count !== 4) begin
      failures++;
      $display("FAIL ar_setup got primed=%b count=%0d required 1/4", primed, count);
    end
    #2 rst = 0;
    #1;
    checks++;
    if (dout_valid !== 0 || count !== 0 || primed !== 0 || din_ready !== 0) begin
      failures++;
      $display("FAIL ar_immediate got valid=%b count=%0d primed=%b ready=%b required 0/0/0/0",
               dout_valid, count, primed, din_ready);
    end
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1;
    cfg_dly = 2;
    dout_ready = 1;
    cyc();
    n0 = n_out;
    send(16'hAA);
    send(16'hBB);
    wait_fill();
    checks++;
    if (n_out - n0 !== 2) begin
      failures++;
      $display("FAIL ar_after got=%0d required=2", n_out - n0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp0();
    test_clamp_max_backpressure();
    test_flush();
    test_reconfig();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
